nrda_div_ctrl: RTL and testbench

- Sequential issue/retire stage wrapped around the combinational unsigned non-restoring divider array nrda_div.
- Accepts operands over a valid/ready handshake and registers them, so the array sees stable inputs for a fixed multicycle window of LAT clocks.
- Captures quotient/remainder into output registers and presents them over a valid/ready handshake.
- Detects divide-by-zero without waiting on the array.

---
 rtl/nrda_div_ctrl_pkg.sv | 12 +
 rtl/nrda_div_ctrl_if.sv | 24 ++
 rtl/nrda_div_ctrl_div.sv | 38 +++
 rtl/nrda_div_ctrl.sv | 93 +++++++++
 tb/tb_nrda_div_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/nrda_div_ctrl_pkg.sv
// Shared types and constants for the non-restoring divider issue/retire stage.
package nrda_div_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/nrda_div_ctrl_if.sv
// Operand/result handshake bundle for nrda_div_ctrl.
interface nrda_div_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_r;
    logic             out_dz;

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_q, out_r, out_dz
    );

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_q, out_r, out_dz
    );
endinterface

// File: rtl/nrda_div_ctrl_div.sv
// Combinational unsigned non-restoring divider array (nrda_div).
module nrda_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);
    // Partial remainder stays in [-y, y); the shifted value needs two extra bits.
    logic [WIDTH+1:0] rem;
    logic [WIDTH+1:0] sh;
    logic [WIDTH+1:0] ye;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] quo;

    always_comb begin
        ye  = {2'b00, y};
        xs  = x;
        rem = '0;
        sh  = '0;
        quo = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            sh = {rem[WIDTH:0], xs[WIDTH-1]};
            if (rem[WIDTH+1])
                rem = sh + ye;
            else
                rem = sh - ye;
            quo = {quo[WIDTH-2:0], ~rem[WIDTH+1]};
            xs  = xs << 1;
        end
        if (rem[WIDTH+1])
            rem = rem + ye;
    end

    assign q = quo;
    assign r = rem[WIDTH-1:0];
endmodule

// File: rtl/nrda_div_ctrl.sv
// Issue/retire stage: registers operands, gives nrda_div LAT cycles to settle,
// and holds the quotient/remainder until the consumer takes them.
module nrda_div_ctrl
    import nrda_div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LAT   = 4
) (
    input logic        clk,
    input logic        rst_n,
    nrda_div_ctrl_if.slave bus
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] q_arr;
    logic [WIDTH-1:0] r_arr;
    logic [WIDTH-1:0] out_q_r;
    logic [WIDTH-1:0] out_r_r;
    logic             out_dz_r;
    logic             out_valid_r;
    logic             in_ready;
    logic             accept;

    nrda_div #(.WIDTH(WIDTH)) u_div (
        .x (x_reg),
        .y (y_reg),
        .q (q_arr),
        .r (r_arr)
    );

    assign in_ready = (state == ST_IDLE) || (state == ST_DONE && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            out_q_r     <= '0;
            out_r_r     <= '0;
            out_dz_r    <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // Retire and issue share this branch so DONE can accept in the same cycle.
                    if (accept) begin
                        x_reg <= bus.in_x;
                        y_reg <= bus.in_y;
                        if (bus.in_y == '0) begin
                            state       <= ST_DONE;
                            out_valid_r <= 1'b1;
                            out_q_r     <= '1;
                            out_r_r     <= bus.in_x;
                            out_dz_r    <= 1'b1;
                        end else begin
                            state       <= ST_WAIT;
                            out_valid_r <= 1'b0;
                            cnt         <= CNT_W'(LAT - 1);
                            out_dz_r    <= 1'b0;
                        end
                    end else if (state == ST_DONE && bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state       <= ST_DONE;
                        out_valid_r <= 1'b1;
                        out_q_r     <= q_arr;
                        out_r_r     <= r_arr;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_r;
    assign bus.out_q     = out_q_r;
    assign bus.out_r     = out_r_r;
    assign bus.out_dz    = out_dz_r;
endmodule

// File: tb/tb_nrda_div_ctrl.sv
// Directed self-checking bench for nrda_div_ctrl (WIDTH=32, LAT=4).
module tb_nrda_div_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;

    nrda_div_ctrl_if #(.WIDTH(32)) bus ();

    nrda_div_ctrl #(.WIDTH(32), .LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) for out_valid, counting negedges from the negedge after accept.
    task automatic wait_result();
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_x      = 32'd123;
        bus.in_y      = 32'd4;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_q !== 32'd0) begin n_fail++; $display("FAIL reset_out_q got %h want 0", bus.out_q); end
        n_checks++; if (bus.out_r !== 32'd0) begin n_fail++; $display("FAIL reset_out_r got %h want 0", bus.out_r); end
        n_checks++; if (bus.out_dz !== 1'b0) begin n_fail++; $display("FAIL reset_out_dz got %b want 0", bus.out_dz); end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        issue(32'd1436, 32'd135);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy valid=%b ready=%b want 0/0", bus.out_valid, bus.in_ready);
        end
        wait_result();
        n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL basic_latency got %0d want 4", cyc); end
        n_checks++; if (bus.out_q !== 32'd10) begin n_fail++; $display("FAIL basic_q got %0d want 10", bus.out_q); end
        n_checks++; if (bus.out_r !== 32'd86) begin n_fail++; $display("FAIL basic_r got %0d want 86", bus.out_r); end
        n_checks++; if (bus.out_dz !== 1'b0) begin n_fail++; $display("FAIL basic_dz got %b want 0", bus.out_dz); end
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_retire valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_divzero();
        bus.out_ready = 1'b1;
        issue(32'd77, 32'd0);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL dz_latency valid got %b want 1", bus.out_valid); end
        n_checks++; if (bus.out_q !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dz_q got %h want ffffffff", bus.out_q); end
        n_checks++; if (bus.out_r !== 32'd77) begin n_fail++; $display("FAIL dz_r got %0d want 77", bus.out_r); end
        n_checks++; if (bus.out_dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", bus.out_dz); end
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL dz_retire valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        issue(32'd100, 32'd7);
        wait_result();
        n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL bp_latency got %0d want 4", cyc); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_q !== 32'd14 || bus.out_r !== 32'd2 || bus.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d] valid=%b q=%0d r=%0d ready=%b want 1/14/2/0",
                                   i, bus.out_valid, bus.out_q, bus.out_r, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_x      = 32'hFFFFFFFF;
        bus.in_y      = 32'd1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_on_retire got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_reissue_valid got %b want 0", bus.out_valid); end
        wait_result();
        n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL bp2_latency got %0d want 4", cyc); end
        n_checks++; if (bus.out_q !== 32'hFFFFFFFF || bus.out_r !== 32'd0) begin
            n_fail++; $display("FAIL bp2_result q=%h r=%h want ffffffff/0", bus.out_q, bus.out_r);
        end
        @(negedge clk);
    endtask

    task automatic test_stable();
        bus.out_ready = 1'b1;
        issue(32'd1000, 32'd33);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            bus.in_x = $urandom;
            bus.in_y = $urandom;
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL stable_latency got %0d want 4", cyc); end
        n_checks++; if (bus.out_q !== 32'd30 || bus.out_r !== 32'd10) begin
            n_fail++; $display("FAIL stable_result q=%0d r=%0d want 30/10", bus.out_q, bus.out_r);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        issue(32'd500, 32'd9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_stale[%0d] valid got %b want 0", i, bus.out_valid); end
        end
        issue(32'd9, 32'd500);
        wait_result();
        n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL midreset_latency got %0d want 4", cyc); end
        n_checks++; if (bus.out_q !== 32'd0 || bus.out_r !== 32'd9) begin
            n_fail++; $display("FAIL midreset_result q=%0d r=%0d want 0/9", bus.out_q, bus.out_r);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vx [6];
        logic [31:0] vy [6];
        logic [31:0] vq [6];
        logic [31:0] vr [6];
        vx = '{32'd0, 32'd7, 32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'd5};
        vy = '{32'd5, 32'd7, 32'hFFFFFFFF, 32'd3,        32'h00010000, 32'hFFFFFFFF};
        vq = '{32'd0, 32'd1, 32'd1,        32'h2AAAAAAA, 32'h00001234, 32'd0};
        vr = '{32'd0, 32'd0, 32'd0,        32'd2,        32'h00005678, 32'd5};
        bus.out_ready = 1'b1;
        issue(vx[0], vy[0]);
        for (int i = 0; i < 6; i++) begin
            wait_result();
            n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL b2b_latency[%0d] got %0d want 4", i, cyc); end
            n_checks++; if (bus.out_q !== vq[i] || bus.out_r !== vr[i]) begin
                n_fail++; $display("FAIL b2b_result[%0d] q=%h r=%h want %h/%h", i, bus.out_q, bus.out_r, vq[i], vr[i]);
            end
            if (i < 5) issue(vx[i+1], vy[i+1]);
            else @(negedge clk);
        end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_final valid got %b want 0", bus.out_valid); end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_divzero();
        test_backpressure();
        test_stable();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
